// File: rtl/triangle_test_ctrl_pkg.sv
// triangle_test_ctrl_pkg: shared constants and types for the point-in-triangle controller
package triangle_test_ctrl_pkg;
  localparam int CW = 11;
  localparam int AW = 24;
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SUM, S_OUT} state_e;
  typedef logic [1:0] idx_t;
endpackage

// File: rtl/tri_operand_mux.sv
// tri_operand_mux: selects the three operand points for area request k
// (points 0..2 are the vertices, point 3 is the test point; [0]=x, [1]=y)
module tri_operand_mux
  import triangle_test_ctrl_pkg::*;
#(
  parameter int W = 11
) (
  input  idx_t                   k_i,
  input  logic [3:0][1:0][W-1:0] pts_i,
  output logic signed [W:0]      ax_o,
  output logic signed [W:0]      ay_o,
  output logic signed [W:0]      bx_o,
  output logic signed [W:0]      by_o,
  output logic signed [W:0]      cx_o,
  output logic signed [W:0]      cy_o
);
  logic [1:0] a, b, c;
  always_comb begin
    a = (k_i < 2'd2) ? 2'd0 : k_i - 2'd1;
    b = (k_i < 2'd2) ? 2'd1 : (k_i == 2'd2) ? 2'd2 : 2'd0;
    c = (k_i == 2'd0) ? 2'd2 : 2'd3;
    ax_o = {1'b0, pts_i[a][0]};
    ay_o = {1'b0, pts_i[a][1]};
    bx_o = {1'b0, pts_i[b][0]};
    by_o = {1'b0, pts_i[b][1]};
    cx_o = {1'b0, pts_i[c][0]};
    cy_o = {1'b0, pts_i[c][1]};
  end
endmodule

// File: rtl/triangle_test_ctrl.sv
// triangle_test_ctrl: sequences four area requests on a shared area unit and
// decides whether the test point lies inside (or on an edge of) the triangle
module triangle_test_ctrl #(
  parameter int CW       = triangle_test_ctrl_pkg::CW,
  parameter int AW       = triangle_test_ctrl_pkg::AW,
  parameter int MAX_WAIT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CW-1:0]        p1x,
  input  logic [CW-1:0]        p1y,
  input  logic [CW-1:0]        p2x,
  input  logic [CW-1:0]        p2y,
  input  logic [CW-1:0]        p3x,
  input  logic [CW-1:0]        p3y,
  input  logic [CW-1:0]        ptx,
  input  logic [CW-1:0]        pty,
  output logic                 ar_start,
  output logic signed [CW:0]   ar_ax,
  output logic signed [CW:0]   ar_ay,
  output logic signed [CW:0]   ar_bx,
  output logic signed [CW:0]   ar_by,
  output logic signed [CW:0]   ar_cx,
  output logic signed [CW:0]   ar_cy,
  input  logic                 ar_done,
  input  logic signed [AW-1:0] ar_area,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_inside,
  output logic                 out_degen,
  output logic                 out_err
);
  import triangle_test_ctrl_pkg::*;
  localparam int WW = $clog2(MAX_WAIT + 1);
  state_e                 state_q, state_d;
  idx_t                   k_q, k_d;
  logic [3:0][1:0][CW-1:0] pts_q, pts_d;
  logic [AW:0]            afull_q, afull_d;
  logic [AW+1:0]          sum_q, sum_d;
  logic [WW-1:0]          wd_q, wd_d;
  logic                   inside_q, inside_d, degen_q, degen_d, err_q, err_d;
  logic signed [AW:0]     area_x;
  logic [AW:0]            mag;
  logic signed [CW:0]     m_ax, m_ay, m_bx, m_by, m_cx, m_cy;
  tri_operand_mux #(.W(CW)) u_mux (
    .k_i  (k_d),
    .pts_i(pts_d),
    .ax_o (m_ax),
    .ay_o (m_ay),
    .bx_o (m_bx),
    .by_o (m_by),
    .cx_o (m_cx),
    .cy_o (m_cy)
  );
  assign area_x    = {ar_area[AW-1], ar_area};
  assign mag       = area_x[AW] ? -area_x : area_x;
  assign in_ready  = state_q == S_IDLE;
  assign ar_start  = state_q == S_ISSUE;
  assign out_valid = state_q == S_OUT;
  assign out_inside = inside_q;
  assign out_degen  = degen_q;
  assign out_err    = err_q;
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    pts_d    = pts_q;
    afull_d  = afull_q;
    sum_d    = sum_q;
    wd_d     = wd_q;
    inside_d = inside_q;
    degen_d  = degen_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        pts_d   = {pty, ptx, p3y, p3x, p2y, p2x, p1y, p1x};
        k_d     = '0;
        afull_d = '0;
        sum_d   = '0;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        wd_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (ar_done) begin
        afull_d = (k_q == 2'd0) ? mag : afull_q;
        sum_d   = (k_q == 2'd0) ? sum_q : sum_q + {1'b0, mag};
        k_d     = (k_q == 2'd3) ? k_q : k_q + 2'd1;
        state_d = (k_q == 2'd3) ? S_SUM : S_ISSUE;
      end else if (wd_q == WW'(MAX_WAIT - 1)) begin
        err_d    = 1'b1;
        inside_d = 1'b0;
        degen_d  = 1'b0;
        state_d  = S_OUT;
      end else begin
        wd_d = wd_q + 1'b1;
      end
      S_SUM: begin
        degen_d  = afull_q == '0;
        inside_d = (afull_q != '0) && (sum_q == {1'b0, afull_q});
        err_d    = 1'b0;
        state_d  = S_OUT;
      end
      S_OUT: state_d = out_ready ? S_IDLE : S_OUT;
      default: state_d = S_IDLE;
    endcase
  end
  // operands are loaded on entry to ISSUE and then held through WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      pts_q    <= '0;
      afull_q  <= '0;
      sum_q    <= '0;
      wd_q     <= '0;
      inside_q <= 1'b0;
      degen_q  <= 1'b0;
      err_q    <= 1'b0;
      ar_ax    <= '0;
      ar_ay    <= '0;
      ar_bx    <= '0;
      ar_by    <= '0;
      ar_cx    <= '0;
      ar_cy    <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      pts_q    <= pts_d;
      afull_q  <= afull_d;
      sum_q    <= sum_d;
      wd_q     <= wd_d;
      inside_q <= inside_d;
      degen_q  <= degen_d;
      err_q    <= err_d;
      if (state_d == S_ISSUE) begin
        ar_ax <= m_ax;
        ar_ay <= m_ay;
        ar_bx <= m_bx;
        ar_by <= m_by;
        ar_cx <= m_cx;
        ar_cy <= m_cy;
      end
    end
  end
endmodule

// File: tb/tb_triangle_test_ctrl.sv
// tb_triangle_test_ctrl: randomized and directed bench with an area-unit model
// and a geometric reference for the inside/outside verdict
module tb_triangle_test_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0, ar_done = 1'b0;
  logic in_ready, ar_start, out_valid, out_inside, out_degen, out_err;
  logic [10:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0, ptx = '0, pty = '0;
  logic signed [11:0] ar_ax, ar_ay, ar_bx, ar_by, ar_cx, ar_cy;
  logic signed [23:0] ar_area = '0;
  int tests = 0, fails = 0;
  int lat = 3;
  bit resp_en = 1'b1;
  int pend = 0;

  triangle_test_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y), .p3x(p3x), .p3y(p3y), .ptx(ptx), .pty(pty),
    .ar_start(ar_start), .ar_ax(ar_ax), .ar_ay(ar_ay), .ar_bx(ar_bx), .ar_by(ar_by),
    .ar_cx(ar_cx), .ar_cy(ar_cy), .ar_done(ar_done), .ar_area(ar_area),
    .out_valid(out_valid), .out_ready(out_ready), .out_inside(out_inside),
    .out_degen(out_degen), .out_err(out_err)
  );

  always #5 clk = ~clk;

  function automatic int area2(int ax, int ay, int bx, int by, int cx, int cy);
    return (bx - ax) * (cy - ay) - (cx - ax) * (by - ay);
  endfunction

  function automatic int iabs(int v);
    return v < 0 ? -v : v;
  endfunction

  // expected {inside, degen, err} from the triangle geometry
  function automatic logic [2:0] ref_verdict(int x1, int y1, int x2, int y2, int x3, int y3, int tx, int ty);
    int full, s;
    full = iabs(area2(x1, y1, x2, y2, x3, y3));
    s = iabs(area2(x1, y1, x2, y2, tx, ty)) + iabs(area2(x2, y2, x3, y3, tx, ty)) + iabs(area2(x3, y3, x1, y1, tx, ty));
    return {full != 0 && s == full, full == 0, 1'b0};
  endfunction

  // area unit: answers L cycles after seeing ar_start, using the held operands
  initial begin
    int a;
    forever begin
      @(posedge clk);
      #1;
      ar_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          a = area2(ar_ax, ar_ay, ar_bx, ar_by, ar_cx, ar_cy);
          ar_area = a[23:0];
          ar_done = 1'b1;
        end
      end
      if (ar_start && resp_en) pend = lat;
    end
  end

  task automatic run_job(input int x1, input int y1, input int x2, input int y2, input int x3, input int y3,
                         input int tx, input int ty, output int n, output logic [2:0] flags);
    int g = 0;
    p1x = x1[10:0]; p1y = y1[10:0]; p2x = x2[10:0]; p2y = y2[10:0];
    p3x = x3[10:0]; p3y = y3[10:0]; ptx = tx[10:0]; pty = ty[10:0];
    in_valid = 1'b1;
    while (!in_ready && g < 400) begin
      @(posedge clk); #1; g++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    flags = {out_inside, out_degen, out_err};
  endtask

  task automatic finish_job();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({in_ready, ar_start, out_valid, out_inside, out_degen, out_err} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 100000", {in_ready, ar_start, out_valid, out_inside, out_degen, out_err});
    end
    tests++;
    if ({ar_ax, ar_ay, ar_bx, ar_by, ar_cx, ar_cy} !== 72'd0) begin
      fails++;
      $display("FAIL reset_operands: got %h expected 0", {ar_ax, ar_ay, ar_bx, ar_by, ar_cx, ar_cy});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int c[5][8] = '{'{0, 0, 10, 0, 0, 10, 2, 2}, '{0, 0, 10, 0, 0, 10, 8, 8}, '{0, 0, 10, 0, 0, 10, 5, 5},
                    '{0, 0, 5, 5, 10, 10, 5, 5}, '{0, 0, 10, 0, 0, 10, 0, 0}};
    logic [2:0] e[5] = '{3'b100, 3'b000, 3'b100, 3'b010, 3'b100};
    int n;
    logic [2:0] f;
    lat = 3;
    for (int i = 0; i < 5; i++) begin
      run_job(c[i][0], c[i][1], c[i][2], c[i][3], c[i][4], c[i][5], c[i][6], c[i][7], n, f);
      tests++;
      if (f !== e[i]) begin
        fails++;
        $display("FAIL directed%0d_flags: got %b expected %b", i, f, e[i]);
      end
      tests++;
      if (n != 18) begin
        fails++;
        $display("FAIL directed%0d_latency: got %0d expected 18", i, n);
      end
      finish_job();
    end
  endtask

  task automatic test_timeout();
    int n;
    bit started, ready_seen;
    resp_en = 1'b0;
    p1x = 11'd0; p1y = 11'd0; p2x = 11'd10; p2y = 11'd0; p3x = 11'd0; p3y = 11'd10; ptx = 11'd2; pty = 11'd2;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    started = ar_start;
    ready_seen = 1'b0;
    while (!out_valid && n < 1000) begin
      ready_seen |= in_ready;
      @(posedge clk); #1; n++;
    end
    tests++;
    if (!started) begin
      fails++;
      $display("FAIL timeout_start: ar_start got 0 expected 1 in cycle 1");
    end
    tests++;
    if (n != 257) begin
      fails++;
      $display("FAIL timeout_latency: got %0d expected 257", n);
    end
    tests++;
    if ({out_inside, out_degen, out_err} !== 3'b001) begin
      fails++;
      $display("FAIL timeout_flags: got %b expected 001", {out_inside, out_degen, out_err});
    end
    tests++;
    if (ready_seen) begin
      fails++;
      $display("FAIL timeout_in_ready: got 1 expected 0 while busy");
    end
    finish_job();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_recover: in_ready got %b expected 1", in_ready);
    end
    resp_en = 1'b1;
  endtask

  task automatic test_hold_and_reset();
    int n, bad;
    logic [2:0] f;
    lat = 3;
    run_job(0, 0, 10, 0, 0, 10, 2, 2, n, f);
    p1x = 11'd100; p2x = 11'd200; ptx = 11'd300;
    in_valid = 1'b1;
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {out_inside, out_degen, out_err} !== f) bad++;
    end
    tests++;
    if (bad != 0 || f !== 3'b100) begin
      fails++;
      $display("FAIL hold_stable: %0d unstable cycles, flags got %b expected 100", bad, f);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL hold_release: {out_valid,in_ready} got %b expected 01", {out_valid, in_ready});
    end
    lat = 5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests++;
    if (ar_start !== 1'b1) begin
      fails++;
      $display("FAIL next_job_start: ar_start got %b expected 1", ar_start);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({in_ready, ar_start, out_valid, out_inside, out_degen, out_err} !== 6'b100000 ||
        {ar_ax, ar_ay, ar_bx, ar_by, ar_cx, ar_cy} !== 72'd0) begin
      fails++;
      $display("FAIL midwait_reset: ctrl got %b expected 100000, operands %h expected 0",
               {in_ready, ar_start, out_valid, out_inside, out_degen, out_err}, {ar_ax, ar_ay, ar_bx, ar_by, ar_cx, ar_cy});
    end
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || ar_start !== 1'b0 || in_ready !== 1'b1) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL late_done_ignored: %0d cycles left IDLE, expected 0", bad);
    end
  endtask

  task automatic test_random();
    int x1, y1, x2, y2, x3, y3, tx, ty, n;
    logic [2:0] f, e;
    for (int i = 0; i < 24; i++) begin
      x1 = $urandom_range(2047); y1 = $urandom_range(2047);
      x2 = $urandom_range(2047); y2 = $urandom_range(2047);
      x3 = $urandom_range(2047); y3 = $urandom_range(2047);
      if (i % 2 == 0) begin
        tx = (x1 + x2 + x3) / 3; ty = (y1 + y2 + y3) / 3;
      end else begin
        tx = $urandom_range(2047); ty = $urandom_range(2047);
      end
      lat = $urandom_range(4, 1);
      e = ref_verdict(x1, y1, x2, y2, x3, y3, tx, ty);
      run_job(x1, y1, x2, y2, x3, y3, tx, ty, n, f);
      tests++;
      if (f !== e || n != 4 * (lat + 1) + 2) begin
        fails++;
        $display("FAIL random%0d: flags got %b expected %b, latency got %0d expected %0d",
                 i, f, e, n, 4 * (lat + 1) + 2);
      end
      finish_job();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_hold_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
